// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen
//   Derives the I2S clock set (mclk, sclk, lrck) from the fabric clock by
//   integer division of one master counter, plus clk-domain strobes that mark
//   sclk edges and frame starts. Runs start and stop only on frame boundaries.
//
// Parameters
//   MCLK_DIV    clk cycles per mclk period (even, >= 2)
//   SCLK_DIV    mclk periods per sclk period (>= 1)
//   FRAME_BITS  sclk periods per lrck period, left + right (even, >= 2)
//
// Ports
//   clk            in   fabric clock
//   rst            in   synchronous active-high reset
//   en             in   run request, acted on only in IDLE or at the last count
//   busy           out  1 while running
//   mclk/sclk/lrck out  registered divided clocks, phase-locked to cnt
//   sclk_fall_stb  out  pulse on the cycle sclk is low at the start of a bit
//   sclk_rise_stb  out  pulse on the cycle sclk goes high
//   frame_stb      out  pulse on the first cycle of each active frame
//
// Configuration
//   I2S_CLK_GEN_STROBE_EN  defined: strobes decoded; undefined: strobes tied 0.

module i2s_clk_gen #(
  parameter int MCLK_DIV   = 4,
  parameter int SCLK_DIV   = 4,
  parameter int FRAME_BITS = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic busy,
  output logic mclk,
  output logic sclk,
  output logic lrck,
  output logic sclk_fall_stb,
  output logic sclk_rise_stb,
  output logic frame_stb
);

  localparam int S  = MCLK_DIV * SCLK_DIV;
  localparam int P  = S * FRAME_BITS;
  localparam int CW = $clog2(P);

  localparam logic [CW-1:0] LAST      = CW'(P - 1);
  localparam logic [CW-1:0] MDIV      = CW'(MCLK_DIV);
  localparam logic [CW-1:0] MHALF     = CW'(MCLK_DIV / 2);
  localparam logic [CW-1:0] SDIV      = CW'(S);
  localparam logic [CW-1:0] SHALF     = CW'(S / 2);
  localparam logic [CW-1:0] FHALF     = CW'(P / 2);

  if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_mclk_div
    $error("i2s_clk_gen: MCLK_DIV must be even and >= 2");
  end
  if (SCLK_DIV < 1) begin : g_bad_sclk_div
    $error("i2s_clk_gen: SCLK_DIV must be >= 1");
  end
  if (FRAME_BITS < 2 || (FRAME_BITS % 2) != 0) begin : g_bad_frame_bits
    $error("i2s_clk_gen: FRAME_BITS must be even and >= 2");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mclk_q, mclk_d;
  logic          sclk_q, sclk_d;
  logic          lrck_q, lrck_d;

  // State register. Clock outputs share the edge with cnt so they are
  // zero-latency relative to it and drop low on the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mclk_q  <= mclk_d;
      sclk_q  <= sclk_d;
      lrck_q  <= lrck_d;
    end
  end

  // Next state. en is only looked at in IDLE and at the last count, so a
  // frame that has started always runs to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = RUN;
          cnt_d   = CW'(1);
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!en) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs. Clocks are decoded from the next count so the flops hold the
  // value matching the registered count; strobes decode the registered count.
  always_comb begin
    mclk_d        = (cnt_d % MDIV) >= MHALF;
    sclk_d        = (cnt_d % SDIV) >= SHALF;
    lrck_d        = cnt_d >= FHALF;
    sclk_fall_stb = 1'b0;
    sclk_rise_stb = 1'b0;
    frame_stb     = 1'b0;
`ifdef I2S_CLK_GEN_STROBE_EN
    // IDLE with en high is the k=0 cycle of the first frame.
    sclk_fall_stb = ((state_q == RUN) || en) && ((cnt_q % SDIV) == '0);
    sclk_rise_stb = (state_q == RUN) && ((cnt_q % SDIV) == SHALF);
    frame_stb     = ((state_q == RUN) || en) && (cnt_q == '0);
`endif
  end

  assign busy = (state_q == RUN);
  assign mclk = mclk_q;
  assign sclk = sclk_q;
  assign lrck = lrck_q;

endmodule
